// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the RAM port arbiter: requester IDs and FSM state encodings.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_PRG  = 2'd2,
        REQ_DBG  = 2'd3
    } req_id_t;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_PROG   = 2'd2
    } arb_state_t;

    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// Saturating starvation counter for the debug port, with clear and a limit-reached flag.
module ram_arb_starve_cnt
    import ram_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic limit_hit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);
    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

    logic [STARVE_CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign limit_hit = (cnt_reg >= LIMIT_V);

endmodule

// File: rtl/ram_port_arbiter.sv
// One-access-per-cycle arbiter for the shared program/data RAM (CPU, programmer, debug)
// with a quiet SETTLE cycle on every program/run mode change.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mode,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adrs,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          prg_req,
    input  logic          prg_we,
    input  logic [AW-1:0] prg_adrs,
    input  logic [DW-1:0] prg_wdata,
    output logic          prg_gnt,
    output logic          prg_rvalid,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_adrs,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_adrs,
    output logic [DW-1:0] ram_data,
    output logic          ram_wr_en,
    input  logic [DW-1:0] ram_q
);

    arb_state_t    state_reg;
    logic          rv_valid_reg;
    req_id_t       rv_id_reg;
    logic [AW-1:0] adrs_reg;
    logic [DW-1:0] data_reg;

    logic          starve_hit;
    req_id_t       winner;
    logic [AW-1:0] win_adrs;
    logic [DW-1:0] win_wdata;
    logic          win_we;

    // Debug steals the slot from the higher-priority requester once starved long enough.
    always_comb begin
        winner = REQ_NONE;
        if (!reset) begin
            unique case (state_reg)
                ST_RUN: begin
                    if (cpu_req && !(dbg_req && starve_hit)) winner = REQ_CPU;
                    else if (dbg_req)                        winner = REQ_DBG;
                end
                ST_PROG: begin
                    if (prg_req && !(dbg_req && starve_hit)) winner = REQ_PRG;
                    else if (dbg_req)                        winner = REQ_DBG;
                end
                default: winner = REQ_NONE;
            endcase
        end
    end

    always_comb begin
        win_adrs  = reset ? '0 : adrs_reg;
        win_wdata = reset ? '0 : data_reg;
        win_we    = 1'b0;
        unique case (winner)
            REQ_CPU: begin
                win_adrs  = cpu_adrs;
                win_wdata = cpu_wdata;
                win_we    = cpu_we;
            end
            REQ_PRG: begin
                win_adrs  = prg_adrs;
                win_wdata = prg_wdata;
                win_we    = prg_we;
            end
            REQ_DBG: win_adrs = dbg_adrs;
            default: ;
        endcase
    end

    assign cpu_gnt   = (winner == REQ_CPU);
    assign prg_gnt   = (winner == REQ_PRG);
    assign dbg_gnt   = (winner == REQ_DBG);
    assign ram_adrs  = win_adrs;
    assign ram_data  = win_wdata;
    assign ram_wr_en = win_we;

    // Gating by reset lets an asserted reset kill a read that is still in flight.
    assign cpu_rvalid = !reset && rv_valid_reg && (rv_id_reg == REQ_CPU);
    assign prg_rvalid = !reset && rv_valid_reg && (rv_id_reg == REQ_PRG);
    assign dbg_rvalid = !reset && rv_valid_reg && (rv_id_reg == REQ_DBG);
    assign rdata      = (!reset && rv_valid_reg) ? ram_q : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_SETTLE;
            rv_valid_reg <= 1'b0;
            rv_id_reg    <= REQ_NONE;
            adrs_reg     <= '0;
            data_reg     <= '0;
        end else begin
            unique case (state_reg)
                ST_SETTLE: state_reg <= mode ? ST_PROG : ST_RUN;
                ST_RUN:    state_reg <= mode ? ST_SETTLE : ST_RUN;
                ST_PROG:   state_reg <= mode ? ST_PROG : ST_SETTLE;
                default:   state_reg <= ST_SETTLE;
            endcase
            rv_valid_reg <= (winner != REQ_NONE) && !win_we;
            rv_id_reg    <= winner;
            adrs_reg     <= win_adrs;
            data_reg     <= win_wdata;
        end
    end

    ram_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clock     (clock),
        .reset     (reset),
        .clr       ((state_reg == ST_SETTLE) || dbg_gnt || !dbg_req),
        .inc       (dbg_req && !dbg_gnt),
        .limit_hit (starve_hit)
    );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a rule-level model checked every cycle plus literal checks.
module tb_ram_port_arbiter;

    localparam int LIM = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode  = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_adrs = '0, cpu_wdata = '0;
    logic       prg_req = 1'b0, prg_we = 1'b0;
    logic [7:0] prg_adrs = '0, prg_wdata = '0;
    logic       dbg_req = 1'b0;
    logic [7:0] dbg_adrs = '0;
    logic       cpu_gnt, cpu_rvalid, prg_gnt, prg_rvalid, dbg_gnt, dbg_rvalid;
    logic [7:0] rdata, ram_adrs, ram_data, ram_q;
    logic       ram_wr_en;
    logic       ram_load = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ram_port_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adrs(cpu_adrs), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .prg_req(prg_req), .prg_we(prg_we), .prg_adrs(prg_adrs), .prg_wdata(prg_wdata),
        .prg_gnt(prg_gnt), .prg_rvalid(prg_rvalid),
        .dbg_req(dbg_req), .dbg_adrs(dbg_adrs), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .rdata(rdata), .ram_adrs(ram_adrs), .ram_data(ram_data), .ram_wr_en(ram_wr_en),
        .ram_q(ram_q)
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 16) ? 8'h5A : 8'(i * 7);
    endfunction

    // RAM with registered read, as attached to the arbiter in the system
    logic [7:0] mem [256];
    always @(posedge clock) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (ram_wr_en) begin
            mem[ram_adrs] <= ram_data;
        end
        ram_q <= mem[ram_adrs];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode phase (0 settle, 1 run, 2 prog), starvation age, pending read, shadow memory
    int         m_phase = 0;
    int         m_starve = 0;
    int         m_pend = 0;
    logic [7:0] m_pend_data = '0;
    logic [7:0] m_last_adrs = '0;
    logic [7:0] shadow [256];

    always @(negedge clock) begin
        int         ew;
        logic [7:0] ea;
        logic [7:0] ed;
        logic       ewe;
        if (ram_load) begin
            for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        end
        if (reset) begin
            check("rst_gnt", {cpu_gnt, prg_gnt, dbg_gnt}, 0);
            check("rst_rvalid", {cpu_rvalid, prg_rvalid, dbg_rvalid}, 0);
            check("rst_wr_en", ram_wr_en, 0);
            check("rst_adrs", ram_adrs, 0);
            check("rst_rdata", rdata, 0);
            m_phase = 0; m_starve = 0; m_pend = 0; m_last_adrs = '0;
        end else begin
            ew = 0;
            if (m_phase == 1) begin
                if (cpu_req && !(dbg_req && m_starve >= LIM)) ew = 1;
                else if (dbg_req) ew = 3;
            end else if (m_phase == 2) begin
                if (prg_req && !(dbg_req && m_starve >= LIM)) ew = 2;
                else if (dbg_req) ew = 3;
            end
            ea  = (ew == 1) ? cpu_adrs : (ew == 2) ? prg_adrs : (ew == 3) ? dbg_adrs : m_last_adrs;
            ed  = (ew == 1) ? cpu_wdata : prg_wdata;
            ewe = (ew == 1 && cpu_we) || (ew == 2 && prg_we);

            check("gnt", {cpu_gnt, prg_gnt, dbg_gnt}, {ew == 1, ew == 2, ew == 3});
            check("rvalid", {cpu_rvalid, prg_rvalid, dbg_rvalid}, {m_pend == 1, m_pend == 2, m_pend == 3});
            if (m_pend != 0) check("rdata", rdata, m_pend_data);
            check("wr_en", ram_wr_en, ewe);
            check("ram_adrs", ram_adrs, ea);
            if (ewe) check("ram_data", ram_data, ed);

            if (ewe) shadow[ea] = ed;
            m_pend      = (ew != 0 && !ewe) ? ew : 0;
            m_pend_data = shadow[ea];
            m_last_adrs = ea;
            if (m_phase == 0 || ew == 3 || !dbg_req) m_starve = 0;
            else if (m_starve < 15) m_starve++;
            if (m_phase == 0)             m_phase = mode ? 2 : 1;
            else if (m_phase == 1 && mode)  m_phase = 0;
            else if (m_phase == 2 && !mode) m_phase = 0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [9:0] cpu_pat, dbg_pat;
        int hits;
        repeat (3) step();

        // Reset release, single CPU read of 0x10
        reset = 1'b0; ram_load = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adrs = 8'h10;
        @(negedge clock); check("lit_t1_settle_gnt", cpu_gnt, 1'b0);
        step(); @(negedge clock); check("lit_t1_cpu_gnt", cpu_gnt, 1'b1);
        step(); cpu_req = 1'b0;
        @(negedge clock); check("lit_t1_rvalid", cpu_rvalid, 1'b1); check("lit_t1_rdata", rdata, 8'h5A);

        // Starvation: CPU and debug both held
        step();
        cpu_req = 1'b1; cpu_adrs = 8'h11; dbg_req = 1'b1; dbg_adrs = 8'h12;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            cpu_pat[k] = cpu_gnt; dbg_pat[k] = dbg_gnt;
            step();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("lit_t2_cpu_pattern", cpu_pat, 10'h1EF);
        check("lit_t2_dbg_pattern", dbg_pat, 10'h210);

        // Program mode: write then debug readback, CPU locked out
        mode = 1'b1;
        repeat (2) step();
        cpu_req = 1'b1; cpu_adrs = 8'h40;
        prg_req = 1'b1; prg_we = 1'b1; prg_adrs = 8'h20; prg_wdata = 8'hA3;
        @(negedge clock);
        check("lit_t3_prg_gnt", prg_gnt, 1'b1); check("lit_t3_wr_en", ram_wr_en, 1'b1);
        check("lit_t3_cpu_gnt", cpu_gnt, 1'b0);
        step(); prg_req = 1'b0; prg_we = 1'b0; dbg_req = 1'b1; dbg_adrs = 8'h20;
        @(negedge clock); check("lit_t3_dbg_gnt", dbg_gnt, 1'b1);
        step(); dbg_req = 1'b0;
        @(negedge clock); check("lit_t3_dbg_rvalid", dbg_rvalid, 1'b1); check("lit_t3_rdata", rdata, 8'hA3);
        cpu_req = 1'b0;

        // CPU read granted in the same cycle the mode flips to program
        mode = 1'b0;
        repeat (3) step();
        cpu_req = 1'b1; cpu_adrs = 8'h10; mode = 1'b1;
        prg_req = 1'b1; prg_we = 1'b0; prg_adrs = 8'h11;
        @(negedge clock); check("lit_t4_cpu_gnt", cpu_gnt, 1'b1);
        step(); cpu_req = 1'b0;
        @(negedge clock);
        check("lit_t4_cpu_rvalid", cpu_rvalid, 1'b1); check("lit_t4_rdata", rdata, 8'h5A);
        check("lit_t4_settle_prg_gnt", prg_gnt, 1'b0);
        step(); @(negedge clock); check("lit_t4_prg_gnt", prg_gnt, 1'b1);
        step(); prg_req = 1'b0;
        @(negedge clock); check("lit_t4_prg_rvalid", prg_rvalid, 1'b1); check("lit_t4_prg_rdata", rdata, 8'h77);

        // Reset right after a debug read grant
        step(); dbg_req = 1'b1; dbg_adrs = 8'h20;
        @(negedge clock); check("lit_t5_dbg_gnt", dbg_gnt, 1'b1);
        step(); dbg_req = 1'b0; reset = 1'b1;
        prg_req = 1'b1; prg_we = 1'b0; prg_adrs = 8'h20;
        @(negedge clock);
        check("lit_t5_dbg_rvalid", dbg_rvalid, 1'b0);
        check("lit_t5_gnts", {cpu_gnt, prg_gnt, dbg_gnt}, 3'b000);
        check("lit_t5_wr_en", ram_wr_en, 1'b0);
        step(); reset = 1'b0;
        @(negedge clock); check("lit_t5_settle_gnt", prg_gnt, 1'b0);
        step(); @(negedge clock); check("lit_t5_prg_gnt", prg_gnt, 1'b1);
        step(); prg_req = 1'b0;
        @(negedge clock); check("lit_t5_rdata", rdata, 8'hA3);

        // Programmer ignored in run mode
        mode = 1'b0;
        repeat (3) step();
        prg_req = 1'b1; prg_we = 1'b1; prg_adrs = 8'h30; prg_wdata = 8'hFF;
        hits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            hits += int'(prg_gnt) + int'(ram_wr_en);
            step();
        end
        prg_req = 1'b0; prg_we = 1'b0;
        check("lit_t6_prg_activity", hits, 0);
        dbg_req = 1'b1; dbg_adrs = 8'h30;
        @(negedge clock); check("lit_t6_dbg_gnt", dbg_gnt, 1'b1);
        step(); dbg_req = 1'b0;
        @(negedge clock); check("lit_t6_rdata", rdata, 8'h50);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
